relu_vec_pipe: RTL and testbench
================================

Name: relu_vec_pipe

Overview:
Multi-lane activation unit that succeeds the single-lane ReLU and is placed between the MAC accumulator and the next-layer buffer of the MNIST accelerator. It processes LANES signed fixed-point values per beat. It supports four run-time modes: ReLU, leaky ReLU, clipped ReLU and pass-through. It is a 2-stage pipeline with a valid/ready handshake and full backpressure. It emits a frame-done pulse on the last beat of each frame.

Parameters:
LANES, 4, lanes processed per beat
DATA_W, 32, bits per lane, two's complement
LEAK_SHIFT, 3, arithmetic right-shift applied to negative inputs in LEAKY mode (slope 1/8)
CLIP_MAX, 6144, upper clamp in CLIP mode, raw signed value (6.0 in Q.10)
CNT_W, 16, width of the zero-count statistics counter (used only when RELU_STATS_EN is defined)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
relu_in  in  LANES*DATA_W  input lanes; lane i occupies bits [i*DATA_W +: DATA_W]
relu_mode  in  2  mode, sampled together with each accepted input beat
relu_in_last  in  1  marks the final beat of a frame
relu_valid  in  1  input beat valid
relu_ready  out  1  unit can accept an input beat this cycle
relu_out  out  LANES*DATA_W  result lanes
relu_out_last  out  1  last flag aligned with relu_out
relu_out_valid  out  1  output beat valid
relu_out_ready  in  1  downstream accepts the output beat
relu_done  out  1  one-cycle pulse when the last beat of a frame is accepted downstream
relu_zero_cnt  out  CNT_W  present only with RELU_STATS_EN

Behaviour:
- Clock and reset:
  - Single clock `clock`. Reset `reset` is synchronous and active-high.
  - Reset clears s1_valid, s2_valid, relu_out_valid, relu_done, relu_out and relu_out_last to 0.
  - Reset overrides any beat in flight. Beats in flight are discarded with no partial output.
- Handshake:
  - An input beat transfers when relu_valid && relu_ready.
  - An output beat transfers when relu_out_valid && relu_out_ready.
  - Once relu_out_valid is raised, relu_out, relu_out_last and relu_out_valid hold stable until the beat transfers.
- Pipeline stages:
  - Stage 1 registers relu_in, relu_mode and relu_in_last.
  - Stage 2 registers the per-lane activation result. Stage-2 registers drive the outputs directly.
- Stall logic:
  - adv2 = !s2_valid || relu_out_ready
  - adv1 = !s1_valid || adv2
  - relu_ready = adv1 (combinational; no combinational path from relu_valid to relu_ready).
- Latency and throughput:
  - 2 cycles from input acceptance to relu_out_valid when not stalled.
  - Throughput is 1 beat per cycle, including while the output is being drained and refilled in the same cycle.
- Per-lane function, with x the signed lane value:
  - Mode 0 RELU: x<0 → 0, else x.
  - Mode 1 LEAKY: x<0 → x>>>LEAK_SHIFT, rounding toward −inf, so −1 → −1; else x.
  - Mode 2 CLIP: x<0 → 0; x>CLIP_MAX → CLIP_MAX; else x.
  - Mode 3 PASS: x unchanged.
  - Lanes are independent, and the mode applies to all lanes of a beat.
  - The most negative value (0x8000_0000) maps to 0 in RELU/CLIP and to 0xF000_0000 in LEAKY.
- Mode changes: mode may change on every beat. Each beat uses the mode captured with it.
- relu_done:
  - Registered. Asserted the cycle after an output transfer with relu_out_last=1, for exactly 1 cycle.
  - Back-to-back single-beat frames produce consecutive pulses.

Optional Feature:
RELU_STATS_EN
- Defined:
  - Adds port relu_zero_cnt plus an internal accumulator.
  - On each output transfer, the accumulator adds the number of lanes whose output equals 0 (0..LANES), saturating at 2^CNT_W−1.
  - On a transfer with last=1, relu_zero_cnt is loaded with the accumulator value including that beat, and the accumulator clears.
  - relu_zero_cnt updates in the same cycle relu_done rises.
  - Reset clears both the accumulator and relu_zero_cnt.
- Not defined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package relu_pkg:
  - Mode constants RELU_MODE_RELU=2'd0, RELU_MODE_LEAKY=2'd1, RELU_MODE_CLIP=2'd2, RELU_MODE_PASS=2'd3.
  - Default widths.
- Sub-module relu_lane: purely combinational single-lane function (x, mode → y), instantiated LANES times in a generate loop.
- Pipeline control, handshake, done and stats logic live in relu_vec_pipe.

Test Plan:
- RELU mode, lanes {5, −7, 0, 0x7FFF_FFFF} with relu_out_ready=1 → 2 cycles later {5, 0, 0, 0x7FFF_FFFF}, relu_out_valid for 1 cycle.
- LEAKY mode, {−64, −1, 40, 0x8000_0000} → {−8, −1, 40, 0xF000_0000}.
- CLIP mode, {7000, 6144, −3, 100} → {6144, 6144, 0, 100}.
- Stream 8 beats with relu_valid held high and relu_out_ready toggling 1,0,0,1,… → all 8 beats emerge in order with no loss or duplication. relu_out is stable while stalled. relu_ready falls only when both stages are full.
- 3-beat frame with last on beat 3, 4 RELU lanes containing 1, 2 and 0 negatives → relu_done pulses once, one cycle after beat 3 transfers. With RELU_STATS_EN, relu_zero_cnt=3.
- Assert reset for 1 cycle while both stages are full → next cycle relu_out_valid=0, relu_done=0, relu_ready=1, and the aborted beats never appear.

Source files
------------

// File: rtl/relu_pkg.sv
// Shared constants for the multi-lane activation unit: mode encodings and default widths.
package relu_pkg;

  localparam logic [1:0] RELU_MODE_RELU  = 2'd0;
  localparam logic [1:0] RELU_MODE_LEAKY = 2'd1;
  localparam logic [1:0] RELU_MODE_CLIP  = 2'd2;
  localparam logic [1:0] RELU_MODE_PASS  = 2'd3;

  localparam int RELU_LANES_DEF      = 4;
  localparam int RELU_DATA_W_DEF     = 32;
  localparam int RELU_LEAK_SHIFT_DEF = 3;
  localparam int RELU_CLIP_MAX_DEF   = 6144;
  localparam int RELU_CNT_W_DEF      = 16;

endpackage

// File: rtl/relu_lane.sv
// Combinational single-lane activation: ReLU, leaky ReLU, clipped ReLU or pass-through.
module relu_lane
  import relu_pkg::*;
#(
  parameter int DATA_W     = RELU_DATA_W_DEF,
  parameter int LEAK_SHIFT = RELU_LEAK_SHIFT_DEF,
  parameter int CLIP_MAX   = RELU_CLIP_MAX_DEF
) (
  input  logic signed [DATA_W-1:0] x_i,
  input  logic        [1:0]        mode_i,
  output logic signed [DATA_W-1:0] y_o
);

  localparam logic signed [DATA_W-1:0] CLIP_V = DATA_W'(CLIP_MAX);

  // Arithmetic shift floors toward -inf, so -1 stays -1 and the most negative value stays negative.
  function automatic logic signed [DATA_W-1:0] leak_floor(input logic signed [DATA_W-1:0] v);
    return v >>> LEAK_SHIFT;
  endfunction

  function automatic logic signed [DATA_W-1:0] clip_sat(input logic signed [DATA_W-1:0] v);
    if (v < 0)
      return '0;
    else if (v > CLIP_V)
      return CLIP_V;
    else
      return v;
  endfunction

  always_comb begin
    y_o = x_i;
    case (mode_i)
      RELU_MODE_RELU:  y_o = x_i[DATA_W-1] ? '0 : x_i;
      RELU_MODE_LEAKY: y_o = x_i[DATA_W-1] ? leak_floor(x_i) : x_i;
      RELU_MODE_CLIP:  y_o = clip_sat(x_i);
      default:         y_o = x_i;
    endcase
  end

endmodule

// File: rtl/relu_vec_pipe.sv
// Two-stage LANES-wide activation pipeline with valid/ready backpressure and frame-done pulse.
// Optional zero-count statistics are enabled by defining RELU_STATS_EN.
module relu_vec_pipe
  import relu_pkg::*;
#(
  parameter int LANES      = RELU_LANES_DEF,
  parameter int DATA_W     = RELU_DATA_W_DEF,
  parameter int LEAK_SHIFT = RELU_LEAK_SHIFT_DEF,
  parameter int CLIP_MAX   = RELU_CLIP_MAX_DEF,
  parameter int CNT_W      = RELU_CNT_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [LANES*DATA_W-1:0] relu_in,
  input  logic [1:0]              relu_mode,
  input  logic                    relu_in_last,
  input  logic                    relu_valid,
  output logic                    relu_ready,
  output logic [LANES*DATA_W-1:0] relu_out,
  output logic                    relu_out_last,
  output logic                    relu_out_valid,
  input  logic                    relu_out_ready,
  output logic                    relu_done
`ifdef RELU_STATS_EN
  ,
  output logic [CNT_W-1:0]        relu_zero_cnt
`endif
);

  logic                    adv1, adv2;
  logic                    vld_p1_q, vld_p1_d;
  logic [LANES*DATA_W-1:0] data_p1_q;
  logic [1:0]              mode_p1_q;
  logic                    last_p1_q;
  logic                    vld_p2_q, vld_p2_d;
  logic [LANES*DATA_W-1:0] data_p2_q, data_p2_d;
  logic                    last_p2_q, last_p2_d;
  logic                    done_q, done_d;
  logic [LANES*DATA_W-1:0] lane_y;

  assign adv2       = !vld_p2_q || relu_out_ready;
  assign adv1       = !vld_p1_q || adv2;
  assign relu_ready = adv1;

  // ---- stage 1: capture input beat ----
  always_ff @(posedge clock) begin
    if (adv1 && relu_valid) begin
      data_p1_q <= relu_in;
      mode_p1_q <= relu_mode;
      last_p1_q <= relu_in_last;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    relu_lane #(
      .DATA_W    (DATA_W),
      .LEAK_SHIFT(LEAK_SHIFT),
      .CLIP_MAX  (CLIP_MAX)
    ) u_lane (
      .x_i   (data_p1_q[g*DATA_W +: DATA_W]),
      .mode_i(mode_p1_q),
      .y_o   (lane_y[g*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    vld_p1_d  = vld_p1_q;
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    last_p2_d = last_p2_q;
    if (adv1)
      vld_p1_d = relu_valid;
    if (adv2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) begin
        data_p2_d = lane_y;
        last_p2_d = last_p1_q;
      end
    end
    done_d = vld_p2_q && relu_out_ready && last_p2_q;
  end

  // ---- stage 2: activation result, drives outputs ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      last_p2_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      last_p2_q <= last_p2_d;
      done_q    <= done_d;
    end
  end

  assign relu_out       = data_p2_q;
  assign relu_out_last  = last_p2_q;
  assign relu_out_valid = vld_p2_q;
  assign relu_done      = done_q;

`ifdef RELU_STATS_EN
  localparam int ZW = $clog2(LANES + 1);

  logic [ZW-1:0]    zeros;
  logic [CNT_W-1:0] acc_q, acc_d, zcnt_q, zcnt_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [ZW-1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(n);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    zeros = '0;
    for (int i = 0; i < LANES; i++)
      if (data_p2_q[i*DATA_W +: DATA_W] == '0)
        zeros = zeros + ZW'(1);
  end

  always_comb begin
    acc_d  = acc_q;
    zcnt_d = zcnt_q;
    if (vld_p2_q && relu_out_ready) begin
      if (last_p2_q) begin
        zcnt_d = sat_add(acc_q, zeros);
        acc_d  = '0;
      end else begin
        acc_d  = sat_add(acc_q, zeros);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      zcnt_q <= '0;
    end else begin
      acc_q  <= acc_d;
      zcnt_q <= zcnt_d;
    end
  end

  assign relu_zero_cnt = zcnt_q;
`endif

endmodule

// File: tb/tb_relu_vec_pipe.sv
// Self-checking bench for relu_vec_pipe: directed vectors, backpressure streaming, frames, reset abort, random traffic.
module tb_relu_vec_pipe;

  localparam int LANES      = 4;
  localparam int DATA_W     = 32;
  localparam int LEAK_SHIFT = 3;
  localparam int CLIP_MAX   = 6144;
  localparam int CNT_W      = 16;
  localparam int W          = LANES * DATA_W;

  logic         clock, reset;
  logic [W-1:0] relu_in;
  logic [1:0]   relu_mode;
  logic         relu_in_last, relu_valid, relu_ready;
  logic [W-1:0] relu_out;
  logic         relu_out_last, relu_out_valid, relu_out_ready, relu_done;
`ifdef RELU_STATS_EN
  logic [CNT_W-1:0] relu_zero_cnt;
`endif

  relu_vec_pipe #(
    .LANES(LANES), .DATA_W(DATA_W), .LEAK_SHIFT(LEAK_SHIFT), .CLIP_MAX(CLIP_MAX), .CNT_W(CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .relu_in       (relu_in),
    .relu_mode     (relu_mode),
    .relu_in_last  (relu_in_last),
    .relu_valid    (relu_valid),
    .relu_ready    (relu_ready),
    .relu_out      (relu_out),
    .relu_out_last (relu_out_last),
    .relu_out_valid(relu_out_valid),
    .relu_out_ready(relu_out_ready),
    .relu_done     (relu_done)
`ifdef RELU_STATS_EN
    ,
    .relu_zero_cnt (relu_zero_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           zeros;
  } beat_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           passes = 0;
  int           done_seen = 0;
  int           zacc_m = 0;
  int           zcnt_m = 0;
  bit           in_acc = 0;
  bit           hold_v = 0;
  logic [W-1:0] held_data;
  logic         held_last;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  // Reference activation from the arithmetic definition (floor division for the leak).
  function automatic logic [DATA_W-1:0] ref_lane(input logic [DATA_W-1:0] xv, input logic [1:0] m);
    longint x, y, d;
    x = longint'($signed(xv));
    d = longint'(1) << LEAK_SHIFT;
    case (m)
      2'd0:    y = (x < 0) ? 0 : x;
      2'd1:    y = (x < 0) ? -((-x + d - 1) / d) : x;
      2'd2:    y = (x < 0) ? 0 : ((x > longint'(CLIP_MAX)) ? longint'(CLIP_MAX) : x);
      default: y = x;
    endcase
    return y[DATA_W-1:0];
  endfunction

  function automatic beat_t mk_beat(input logic [W-1:0] din, input logic [1:0] m, input logic l);
    beat_t b;
    logic [DATA_W-1:0] y;
    b.data  = '0;
    b.last  = l;
    b.zeros = 0;
    for (int i = 0; i < LANES; i++) begin
      y = ref_lane(din[i*DATA_W +: DATA_W], m);
      b.data[i*DATA_W +: DATA_W] = y;
      if (y == '0) b.zeros++;
    end
    return b;
  endfunction

  function automatic logic [W-1:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic int sat_cnt(input int v);
    return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
  endfunction

  // One clock: check handshake/scoreboard before the edge, done/stats after it.
  task automatic cycle();
    beat_t b;
    logic  done_e;
    done_e = 1'b0;
    #1;
    chk("ready", {{(W-1){1'b0}}, relu_ready},
        {{(W-1){1'b0}}, !(exp_q.size() == 2 && !relu_out_ready)});
    if (hold_v) begin
      chk("hold_valid", {{(W-1){1'b0}}, relu_out_valid}, {{(W-1){1'b0}}, 1'b1});
      chk("hold_data", relu_out, held_data);
      chk("hold_last", {{(W-1){1'b0}}, relu_out_last}, {{(W-1){1'b0}}, held_last});
    end
    hold_v    = relu_out_valid && !relu_out_ready;
    held_data = relu_out;
    held_last = relu_out_last;
    if (relu_out_valid && relu_out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", {{(W-1){1'b0}}, relu_out_valid}, '0);
      end else begin
        b = exp_q.pop_front();
        chk("out_data", relu_out, b.data);
        chk("out_last", {{(W-1){1'b0}}, relu_out_last}, {{(W-1){1'b0}}, b.last});
        done_e = b.last;
        if (b.last) begin
          zcnt_m = sat_cnt(zacc_m + b.zeros);
          zacc_m = 0;
        end else begin
          zacc_m = sat_cnt(zacc_m + b.zeros);
        end
      end
    end
    in_acc = relu_valid && relu_ready;
    if (in_acc) exp_q.push_back(mk_beat(relu_in, relu_mode, relu_in_last));
    @(posedge clock);
    #1;
    chk("done", {{(W-1){1'b0}}, relu_done}, {{(W-1){1'b0}}, done_e});
    if (relu_done) done_seen++;
`ifdef RELU_STATS_EN
    chk("zero_cnt", W'(relu_zero_cnt), W'(zcnt_m));
`endif
  endtask

  task automatic new_beat();
    logic [31:0] v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 4))
        0: v = $urandom;
        1: v = 32'($signed($urandom_range(0, 40)) - 20);
        2: v = 32'($urandom_range(CLIP_MAX - 4, CLIP_MAX + 4));
        3: v = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        default: v = 32'(-$signed($urandom_range(1, 100000)));
      endcase
      relu_in[i*DATA_W +: DATA_W] = v;
    end
    relu_mode    = 2'($urandom_range(0, 3));
    relu_in_last = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send_one(input string tag, input logic [W-1:0] din, input logic [1:0] m,
                          input logic [W-1:0] dexp);
    relu_in = din; relu_mode = m; relu_in_last = 1'b1;
    relu_valid = 1'b1; relu_out_ready = 1'b1;
    cycle();
    relu_valid = 1'b0;
    chk({tag, "_lat1"}, {{(W-1){1'b0}}, relu_out_valid}, '0);
    cycle();
    chk({tag, "_lat2"}, {{(W-1){1'b0}}, relu_out_valid}, {{(W-1){1'b0}}, 1'b1});
    chk({tag, "_vec"}, relu_out, dexp);
    cycle();
    chk({tag, "_lat3"}, {{(W-1){1'b0}}, relu_out_valid}, '0);
  endtask

  task automatic drain(input string tag);
    relu_valid = 1'b0;
    relu_out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) cycle();
    chk(tag, W'(exp_q.size()), '0);
  endtask

  initial begin
    int sent, d0;
    logic [W-1:0] fr [3];

    reset = 1'b1; relu_in = '0; relu_mode = 2'd0; relu_in_last = 1'b0;
    relu_valid = 1'b0; relu_out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {{(W-1){1'b0}}, relu_out_valid}, '0);
    chk("rst_done", {{(W-1){1'b0}}, relu_done}, '0);
    chk("rst_ready", {{(W-1){1'b0}}, relu_ready}, {{(W-1){1'b0}}, 1'b1});
    chk("rst_out", relu_out, '0);
    chk("rst_last", {{(W-1){1'b0}}, relu_out_last}, '0);

    send_one("relu", pack4(32'd5, -32'sd7, 32'd0, 32'h7FFF_FFFF), 2'd0,
             pack4(32'd5, 32'd0, 32'd0, 32'h7FFF_FFFF));
    send_one("leaky", pack4(-32'sd64, -32'sd1, 32'd40, 32'h8000_0000), 2'd1,
             pack4(-32'sd8, -32'sd1, 32'd40, 32'hF000_0000));
    send_one("clip", pack4(32'd7000, 32'd6144, -32'sd3, 32'd100), 2'd2,
             pack4(32'd6144, 32'd6144, 32'd0, 32'd100));

    // Streaming under 1,0,0,1 backpressure.
    sent = 0;
    new_beat(); relu_in_last = 1'b0; relu_valid = 1'b1;
    for (int c = 0; c < 80 && (sent < 8 || exp_q.size() != 0); c++) begin
      relu_out_ready = (c % 4 == 0) || (c % 4 == 3);
      cycle();
      if (in_acc) begin
        sent++;
        if (sent < 8) begin
          new_beat();
          relu_in_last = (sent == 7);
        end else begin
          relu_valid = 1'b0;
        end
      end
    end
    chk("stream_sent", W'(sent), W'(8));
    drain("stream_drain");

    // Three-beat RELU frame with 1, 2 and 0 negative lanes.
    fr[0] = pack4(-32'sd3, 32'd4, 32'd5, 32'd6);
    fr[1] = pack4(-32'sd1, -32'sd2, 32'd7, 32'd8);
    fr[2] = pack4(32'd1, 32'd2, 32'd3, 32'd4);
    d0 = done_seen;
    relu_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      relu_in = fr[i]; relu_mode = 2'd0; relu_in_last = (i == 2); relu_valid = 1'b1;
      cycle();
    end
    drain("frame_drain");
    cycle();
    chk("frame_done_cnt", W'(done_seen - d0), W'(1));
`ifdef RELU_STATS_EN
    chk("frame_zero_cnt", W'(relu_zero_cnt), W'(3));
`endif

    // Back-to-back single-beat frames give consecutive done pulses.
    d0 = done_seen;
    for (int i = 0; i < 3; i++) begin
      new_beat(); relu_in_last = 1'b1; relu_valid = 1'b1; relu_out_ready = 1'b1;
      cycle();
    end
    drain("b2b_drain");
    cycle();
    chk("b2b_done_cnt", W'(done_seen - d0), W'(3));

    // Random traffic.
    relu_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!relu_valid || in_acc) begin
        relu_valid = ($urandom_range(0, 9) < 7);
        if (relu_valid) new_beat();
      end
      relu_out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain("rand_drain");

    // Reset abort with both stages full.
    relu_out_ready = 1'b0;
    new_beat(); relu_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (in_acc) new_beat();
    end
    chk("full_ready", {{(W-1){1'b0}}, relu_ready}, '0);
    reset = 1'b1; relu_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete(); zacc_m = 0; zcnt_m = 0; hold_v = 0;
    #1;
    chk("abort_out_valid", {{(W-1){1'b0}}, relu_out_valid}, '0);
    chk("abort_done", {{(W-1){1'b0}}, relu_done}, '0);
    chk("abort_ready", {{(W-1){1'b0}}, relu_ready}, {{(W-1){1'b0}}, 1'b1});
    relu_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) cycle();
    chk("abort_quiet", {{(W-1){1'b0}}, relu_out_valid}, '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
